// File: rtl/trace_pkg.sv
// Shared types for the logic-analyser style trace capture block.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TM_EQUAL     = 2'd0,
    TM_RISE      = 2'd1,
    TM_CHANGE    = 2'd2,
    TM_IMMEDIATE = 2'd3
  } trig_mode_e;

  // Address width for a buffer of 'depth' samples; never narrower than 1 bit.
  function automatic int trace_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int  DATA_W = 54,
  parameter int  DEPTH  = 1024,
  localparam int AW     = trace_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Output register carries the sync reset so rd_data powers up clean.
  always_ff @(posedge clk) begin
    if (!rst_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_capture.sv
// Circular-buffer trace capture: pre-trigger fill, trigger wait, post-trigger fill,
// then indexed readout with index 0 being the oldest retained sample.
module trace_capture
  import trace_pkg::*;
#(
  parameter int  DATA_W = 54,
  parameter int  DEPTH  = 1024,
  localparam int AW     = trace_aw(DEPTH)
) (
  input  logic              clk_27,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [AW-1:0]     pretrig_i,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  state_e            state, state_nxt;
  trig_mode_e        cfg_mode;
  logic [DATA_W-1:0] cfg_val, cfg_mask, prev_probe;
  logic [AW-1:0]     pre_len, post_len, wr_ptr, cnt, trig_addr, rd_base, rd_addr;
  logic              prev_vld, rd_vld, capturing, arm_go, hit, trig_hit, rd_req;

  // Post-trigger length: DEPTH-1 is all ones because DEPTH is a power of two.
  assign post_len = {AW{1'b1}} - pre_len;
  assign arm_go   = arm_i && (state == ST_IDLE || state == ST_DONE);

  // Trigger evaluation against the latched configuration.
  always_comb begin
    hit = 1'b0;
    unique case (cfg_mode)
      TM_EQUAL:  hit = ~|((probe_i ^ cfg_val) & cfg_mask);
      TM_RISE:   hit = prev_vld & |(~prev_probe & probe_i & cfg_mask);
      TM_CHANGE: hit = prev_vld & |((prev_probe ^ probe_i) & cfg_mask);
      default:   hit = 1'b1;
    endcase
    trig_hit = (state == ST_WAIT) && hit;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm_i) state_nxt = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
        ST_PRE:           if (cnt == pre_len - 1'b1) state_nxt = ST_WAIT;
        // A full pre-trigger window leaves nothing for POST to write.
        ST_WAIT:          if (trig_hit) state_nxt = (post_len == '0) ? ST_DONE : ST_POST;
        ST_POST:          if (cnt == post_len - 1'b1) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and capture datapath.
  always_ff @(posedge clk_27) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cfg_mode   <= TM_EQUAL;
      cfg_val    <= '0;
      cfg_mask   <= '0;
      pre_len    <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      trig_addr  <= '0;
      prev_probe <= '0;
      prev_vld   <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= rd_req;
      if (abort_i) begin
        prev_vld <= 1'b0;
      end else if (arm_go) begin
        cfg_mode <= trig_mode_e'(trig_mode_i);
        cfg_val  <= trig_val_i;
        cfg_mask <= trig_mask_i;
        // pretrig_i is AW bits wide, so it can never exceed DEPTH-1.
        pre_len  <= pretrig_i;
        wr_ptr   <= '0;
        cnt      <= '0;
        prev_vld <= 1'b0;
      end else if (capturing) begin
        wr_ptr     <= wr_ptr + 1'b1;
        cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
        prev_probe <= probe_i;
        prev_vld   <= 1'b1;
        if (trig_hit) trig_addr <= wr_ptr;
      end
    end
  end

  // Outputs.
  always_comb begin
    capturing = 1'b0;
    case (state)
      ST_PRE, ST_WAIT, ST_POST: capturing = 1'b1;
      default:                  capturing = 1'b0;
    endcase
    state_o     = state;
    done_o      = (state == ST_DONE);
    trig_addr_o = trig_addr;
    rd_valid_o  = rd_vld;
    rd_req      = rd_en_i && (state == ST_DONE);
  end

  assign rd_base = trig_addr - pre_len;
  assign rd_addr = rd_base + rd_idx_i;

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk_27),
    .rst_n   (rst_n),
    .we      (capturing),
    .wr_addr (wr_ptr),
    .wr_data (probe_i),
    .re      (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data_o)
  );

endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture against a sample-history reference model.
module tb_trace_capture;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int N      = 256;

  logic              clk_27 = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] probe_i = '0, trig_val_i = '0, trig_mask_i = '0, rd_data_o;
  logic              arm_i = 1'b0, abort_i = 1'b0, rd_en_i = 1'b0, done_o, rd_valid_o;
  logic [1:0]        trig_mode_i = '0;
  logic [AW-1:0]     pretrig_i = '0, rd_idx_i = '0, trig_addr_o;
  logic [2:0]        state_o;

  int errs = 0, checks = 0;
  logic [DATA_W-1:0] seq [N];

  trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_27(clk_27), .rst_n(rst_n), .probe_i(probe_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_mode_i(trig_mode_i), .trig_val_i(trig_val_i), .trig_mask_i(trig_mask_i),
    .pretrig_i(pretrig_i), .state_o(state_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
  );

  always #5 clk_27 = ~clk_27;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_27);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the first sample in seq[] that fires the trigger, or -1.
  function automatic int find_trig(input int mode, input logic [DATA_W-1:0] val,
                                   input logic [DATA_W-1:0] mask, input int pre);
    for (int i = pre; i < N; i++) begin
      case (mode)
        0: if (((seq[i] ^ val) & mask) == '0) return i;
        1: if (i > 0 && ((~seq[i-1] & seq[i] & mask) != '0)) return i;
        2: if (i > 0 && (((seq[i-1] ^ seq[i]) & mask) != '0)) return i;
        default: return i;
      endcase
    end
    return -1;
  endfunction

  task automatic run_capture(input int mode, input logic [DATA_W-1:0] val,
                             input logic [DATA_W-1:0] mask, input int pre);
    int ti, e, exp_st;
    ti = find_trig(mode, val, mask, pre);
    if (ti < 0 || ti + DEPTH - 1 - pre >= N) begin
      $display("note: stimulus without usable trigger skipped");
      return;
    end
    e = ti + DEPTH - 1 - pre;
    trig_mode_i = mode[1:0]; trig_val_i = val; trig_mask_i = mask; pretrig_i = pre[AW-1:0];
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("arm_state", state_o, (pre == 0) ? 2 : 1);
    for (int n = 0; n <= e; n++) begin
      probe_i     = seq[n];
      trig_mode_i = 2'($urandom);
      trig_val_i  = DATA_W'($urandom);
      trig_mask_i = DATA_W'($urandom);
      pretrig_i   = AW'($urandom);
      arm_i       = ($urandom_range(7) == 0);
      step();
      arm_i = 1'b0;
      if (n == e)       exp_st = 4;
      else if (n >= ti) exp_st = 3;
      else if (n + 1 < pre) exp_st = 1;
      else              exp_st = 2;
      chk("state", state_o, exp_st);
      chk("done", done_o, (n == e));
    end
    chk("trig_addr", trig_addr_o, ti % DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      rd_en_i = 1'b1; rd_idx_i = k[AW-1:0];
      step();
      chk("rd_valid", rd_valid_o, 1);
      chk("rd_data", rd_data_o, seq[ti - pre + k]);
    end
    rd_en_i = 1'b0;
    step();
    chk("rd_idle", rd_valid_o, 0);
  endtask

  initial begin
    int mode, pre, ti;
    logic [DATA_W-1:0] val, mask;

    repeat (3) step();
    chk("rst_state", state_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_trig_addr", trig_addr_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    rst_n = 1'b1;
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("idle_read", rd_valid_o, 0);
    arm_i = 1'b1; abort_i = 1'b1;
    step();
    arm_i = 1'b0; abort_i = 1'b0;
    chk("abort_wins", state_o, 0);

    // Counter probe, EQUAL 0x2A, four pre-trigger samples.
    for (int n = 0; n < N; n++) seq[n] = DATA_W'(n);
    run_capture(0, 16'h002A, 16'hFFFF, 4);

    // Bit 3 toggling every 5 samples, RISE on bit 3, no pre-trigger.
    for (int n = 0; n < N; n++) seq[n] = (((n / 5) % 2) ? 16'h0008 : 16'h0000) | (16'($urandom) & 16'hFFF7);
    run_capture(1, 16'h0000, 16'h0008, 0);

    // IMMEDIATE with a full pre-trigger window.
    for (int n = 0; n < N; n++) seq[n] = 16'($urandom);
    run_capture(3, 16'h0000, 16'h0000, 15);

    // EQUAL with empty mask fires on the first WAIT sample.
    run_capture(0, 16'($urandom), 16'h0000, 6);

    // Long WAIT across several pointer wraps.
    for (int n = 0; n < N; n++) seq[n] = 16'($urandom) & 16'h7FFF;
    seq[90] = seq[90] | 16'h8000;
    run_capture(0, 16'h8000, 16'h8000, 7);

    // Abort while waiting for a trigger that never comes.
    probe_i = '0; trig_mode_i = 2'd0; trig_val_i = 16'h8000; trig_mask_i = 16'h8000; pretrig_i = 4'd2;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    repeat (5) step();
    chk("wait_state", state_o, 2);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_done", done_o, 0);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("abort_read", rd_valid_o, 0);

    // Reset in the middle of POST, then a fresh capture.
    trig_mode_i = 2'd3; pretrig_i = 4'd2;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    repeat (3) begin probe_i = 16'($urandom); step(); end
    chk("post_state", state_o, 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_trig_addr", trig_addr_o, 0);
    chk("mid_rst_rd_valid", rd_valid_o, 0);
    chk("mid_rst_rd_data", rd_data_o, 0);
    rst_n = 1'b1;
    repeat (4) begin step(); chk("after_rst_state", state_o, 0); end
    for (int n = 0; n < N; n++) seq[n] = 16'($urandom);
    run_capture(2, 16'h0000, 16'h00F0, 5);

    // Randomized captures.
    for (int t = 0; t < 10; t++) begin
      for (int tries = 0; tries < 10; tries++) begin
        for (int n = 0; n < N; n++) seq[n] = 16'($urandom);
        mode = $urandom_range(3);
        pre  = $urandom_range(DEPTH - 1);
        val  = 16'($urandom);
        mask = (mode == 0) ? (16'($urandom) & 16'h0007) : (16'($urandom) | 16'h0001);
        ti   = find_trig(mode, val, mask, pre);
        if (ti >= 0 && ti + DEPTH - 1 - pre < N) break;
        mode = 3;
      end
      run_capture(mode, val, mask, pre);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
